spatz_vcfg: RTL

Vector configuration unit for Spatz. It accepts `vsetvli`, `vsetivli` and `vsetvl` requests from the scalar core's offload path. For each request it decodes the raw vtype operand, validates it, computes VLMAX and the new `vl`, and updates the architectural `vtype`, `vl` and `vstart` registers. It returns the new `vl` to the core through a valid/ready response channel, and the vector controller reads the registers as status outputs.

---
 rtl/spatz_vcfg.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/spatz_vcfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spatz_vcfg: vsetvl/vsetvli/vsetivli unit; holds vtype, vl and vstart.     |
// | Optional feature macro: SPATZ_FRAC_LMUL_EN (fractional LMUL F2/F4/F8).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spatz_vcfg #(
  parameter int unsigned VLEN    = 256,
  parameter int unsigned ELEN    = 32,
  parameter int unsigned VlWidth = $clog2(VLEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        req_avl_i,
  input  logic [31:0]        req_vtype_i,
  input  logic               req_rs1_is_x0_i,
  input  logic               req_rd_is_x0_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_vl_o,
  output logic [8:0]         vtype_o,
  output logic [VlWidth-1:0] vl_o,
  output logic [VlWidth-1:0] vstart_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [8:0]  c_vtype_ill  = 9'h100;
  localparam logic [31:0] c_vlen_bytes = 32'(VLEN / 8);
  localparam logic [2:0]  c_elen_log   = 3'($clog2(ELEN / 8));

  state_e               state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          avl_q, avl_d;
  logic [30:0]          raw_q, raw_d;
  logic                 rs1_x0_q, rs1_x0_d;
  logic                 rd_x0_q, rd_x0_d;
  logic [8:0]           vtype_q, vtype_d;
  logic [VlWidth-1:0]   vl_q, vl_d;
  logic [VlWidth-1:0]   vstart_q, vstart_d;
  logic [VlWidth-1:0]   vlmax_q, vlmax_d;
  logic [31:0]          rsp_vl_q, rsp_vl_d;

  // Bit 31 of the raw vtype carries no meaning and is never stored.
  logic unused_vtype_msb;
  assign unused_vtype_msb = req_vtype_i[31];

  logic [2:0]  vlmul;
  logic [2:0]  vsew;
  logic [1:0]  sew_log;
  logic        frac;
  logic        vill;
  logic        keep_vl;
  logic [31:0] base;
  logic [31:0] vlmax;
  logic [31:0] avl_sel;
  logic [31:0] vl_new;
`ifdef SPATZ_FRAC_LMUL_EN
  logic [1:0]  frac_log;
`endif

  always_comb begin
    vlmul   = raw_q[2:0];
    vsew    = raw_q[5:3];
    sew_log = vsew[1:0];
    frac    = vlmul[2];
    vill    = (|raw_q[30:8]) || (vsew > 3'b010) || (vlmul == 3'b100);
    if ((vsew == 3'b010) && (ELEN < 32)) begin
      vill = 1'b1;
    end

    base  = c_vlen_bytes >> sew_log;
    vlmax = base << vlmul[1:0];
`ifdef SPATZ_FRAC_LMUL_EN
    // 101/110/111 encode F8/F4/F2, i.e. a right shift of 4 - vlmul[1:0].
    frac_log = 2'(3'd4 - {1'b0, vlmul[1:0]});
    if (frac) begin
      vlmax = base >> frac_log;
      if (({1'b0, sew_log} + {1'b0, frac_log}) > c_elen_log) begin
        vill = 1'b1;
      end
    end
`else
    if (frac) begin
      vill = 1'b1;
    end
`endif

    keep_vl = rs1_x0_q && rd_x0_q;
    avl_sel = rs1_x0_q ? 32'hFFFF_FFFF : avl_q;
    if (keep_vl) begin
      // Keeping vl is only legal when the ratio SEW/LMUL is unchanged.
      avl_sel = 32'(vl_q);
      if (vlmax != 32'(vlmax_q)) begin
        vill = 1'b1;
      end
    end
    vl_new = (avl_sel <= vlmax) ? avl_sel : vlmax;
  end

  always_comb begin
    state_d  = state_q;
    avl_d    = avl_q;
    raw_d    = raw_q;
    rs1_x0_d = rs1_x0_q;
    rd_x0_d  = rd_x0_q;
    vtype_d  = vtype_q;
    vl_d     = vl_q;
    vstart_d = vstart_q;
    vlmax_d  = vlmax_q;
    rsp_vl_d = rsp_vl_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          avl_d    = req_avl_i;
          raw_d    = req_vtype_i[30:0];
          rs1_x0_d = req_rs1_is_x0_i;
          rd_x0_d  = req_rd_is_x0_i;
          state_d  = CALC;
        end
      end
      CALC: begin
        vstart_d = '0;
        if (vill) begin
          vtype_d  = c_vtype_ill;
          vl_d     = '0;
          vlmax_d  = '0;
          rsp_vl_d = '0;
        end else begin
          vtype_d  = {1'b0, raw_q[7:0]};
          vl_d     = vl_new[VlWidth-1:0];
          vlmax_d  = vlmax[VlWidth-1:0];
          rsp_vl_d = vl_new;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      avl_q       <= '0;
      raw_q       <= '0;
      rs1_x0_q    <= 1'b0;
      rd_x0_q     <= 1'b0;
      vtype_q     <= c_vtype_ill;
      vl_q        <= '0;
      vstart_q    <= '0;
      vlmax_q     <= '0;
      rsp_vl_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      avl_q       <= avl_d;
      raw_q       <= raw_d;
      rs1_x0_q    <= rs1_x0_d;
      rd_x0_q     <= rd_x0_d;
      vtype_q     <= vtype_d;
      vl_q        <= vl_d;
      vstart_q    <= vstart_d;
      vlmax_q     <= vlmax_d;
      rsp_vl_q    <= rsp_vl_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_vl_o    = rsp_vl_q;
  assign vtype_o     = vtype_q;
  assign vl_o        = vl_q;
  assign vstart_o    = vstart_q;

endmodule
`default_nettype wire
